// File: rtl/riscv_pmp_gate.sv
// Single-outstanding access gate: captures one access, consults the PMP checker, then issues it to the BIU or returns a fault.
// Optional alignment check enabled by defining RV_PMPGATE_MISALIGN_CHK_EN.
`timescale 1ns/1ps
module riscv_pmp_gate #(
    parameter int XLEN = 32,
    parameter int PLEN = (XLEN == 32) ? 34 : 56
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            up_req,
    output logic            up_ack,
    input  logic [PLEN-1:0] up_adr,
    input  logic [2:0]      up_size,
    input  logic            up_we,
    input  logic            up_instruction,
    input  logic [XLEN-1:0] up_d,
    output logic            pmp_access_req,
    output logic [PLEN-1:0] pmp_access_adr,
    output logic [2:0]      pmp_access_size,
    output logic            pmp_access_we,
    output logic            pmp_access_instruction,
    input  logic            pmp_access_exception,
    output logic            biu_stb,
    input  logic            biu_stb_ack,
    output logic [PLEN-1:0] biu_adri,
    output logic [2:0]      biu_size,
    output logic            biu_we,
    output logic [XLEN-1:0] biu_d,
    input  logic [XLEN-1:0] biu_q,
    input  logic            biu_ack,
    input  logic            biu_err,
    output logic            rsp_valid,
    output logic [XLEN-1:0] rsp_q,
    output logic            rsp_pmp_fault,
    output logic            rsp_bus_err,
    output logic            rsp_misaligned
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_RESOLVE,
        ST_ISSUE,
        ST_WAIT,
        ST_RSP
    } state_t;

    state_t            state_q, state_d;
    logic [PLEN-1:0]   adr_q, adr_d;
    logic [2:0]        size_q, size_d;
    logic              we_q, we_d;
    logic              instr_q, instr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [XLEN-1:0]   rdata_q, rdata_d;
    logic              pmp_fault_q, pmp_fault_d;
    logic              bus_err_q, bus_err_d;

`ifdef RV_PMPGATE_MISALIGN_CHK_EN
    localparam logic [2:0] SZ_HWORD = 3'b001;
    localparam logic [2:0] SZ_WORD  = 3'b010;
    localparam logic [2:0] SZ_DWORD = 3'b011;

    logic mis_q, mis_d;
    logic misal_q, misal_d;

    function automatic logic is_misaligned(input logic [2:0] a_lo, input logic [2:0] sz);
        logic r;
        r = 1'b0;
        case (sz)
            SZ_HWORD: r = a_lo[0];
            SZ_WORD:  r = |a_lo[1:0];
            SZ_DWORD: r = |a_lo[2:0];
            default:  r = 1'b0;
        endcase
        return r;
    endfunction
`endif

    always_comb begin
        state_d     = state_q;
        adr_d       = adr_q;
        size_d      = size_q;
        we_d        = we_q;
        instr_d     = instr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        pmp_fault_d = pmp_fault_q;
        bus_err_d   = bus_err_q;
`ifdef RV_PMPGATE_MISALIGN_CHK_EN
        mis_d       = mis_q;
        misal_d     = misal_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (up_req) begin
                    adr_d       = up_adr;
                    size_d      = up_size;
                    we_d        = up_we;
                    instr_d     = up_instruction;
                    wdata_d     = up_d;
                    rdata_d     = '0;
                    pmp_fault_d = 1'b0;
                    bus_err_d   = 1'b0;
`ifdef RV_PMPGATE_MISALIGN_CHK_EN
                    misal_d     = 1'b0;
`endif
                    state_d     = ST_CHECK;
                end
            end
            ST_CHECK: begin
`ifdef RV_PMPGATE_MISALIGN_CHK_EN
                mis_d = is_misaligned(adr_q[2:0], size_q);
`endif
                state_d = ST_RESOLVE;
            end
            ST_RESOLVE: begin
                // Misalignment outranks the checker verdict, which is discarded.
`ifdef RV_PMPGATE_MISALIGN_CHK_EN
                if (mis_q) begin
                    misal_d = 1'b1;
                    state_d = ST_RSP;
                end else
`endif
                if (pmp_access_exception) begin
                    pmp_fault_d = 1'b1;
                    state_d     = ST_RSP;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (biu_stb_ack) begin
                    if (biu_err) begin
                        bus_err_d = 1'b1;
                        state_d   = ST_RSP;
                    end else if (biu_ack) begin
                        if (!we_q) rdata_d = biu_q;
                        state_d = ST_RSP;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                // An error beats a simultaneous ack and leaves the read data at zero.
                if (biu_err) begin
                    bus_err_d = 1'b1;
                    state_d   = ST_RSP;
                end else if (biu_ack) begin
                    if (!we_q) rdata_d = biu_q;
                    state_d = ST_RSP;
                end
            end
            ST_RSP:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            adr_q       <= '0;
            size_q      <= '0;
            we_q        <= 1'b0;
            instr_q     <= 1'b0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            pmp_fault_q <= 1'b0;
            bus_err_q   <= 1'b0;
`ifdef RV_PMPGATE_MISALIGN_CHK_EN
            mis_q       <= 1'b0;
            misal_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            adr_q       <= adr_d;
            size_q      <= size_d;
            we_q        <= we_d;
            instr_q     <= instr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            pmp_fault_q <= pmp_fault_d;
            bus_err_q   <= bus_err_d;
`ifdef RV_PMPGATE_MISALIGN_CHK_EN
            mis_q       <= mis_d;
            misal_q     <= misal_d;
`endif
        end
    end

    assign up_ack                 = (state_q == ST_IDLE);
    assign pmp_access_req         = (state_q == ST_CHECK);
    assign pmp_access_adr         = adr_q;
    assign pmp_access_size        = size_q;
    assign pmp_access_we          = we_q;
    assign pmp_access_instruction = instr_q;
    assign biu_stb                = (state_q == ST_ISSUE);
    assign biu_adri               = adr_q;
    assign biu_size               = size_q;
    assign biu_we                 = we_q;
    assign biu_d                  = wdata_q;
    assign rsp_valid              = (state_q == ST_RSP);
    assign rsp_q                  = rdata_q;
    assign rsp_pmp_fault          = pmp_fault_q;
    assign rsp_bus_err            = bus_err_q;
`ifdef RV_PMPGATE_MISALIGN_CHK_EN
    assign rsp_misaligned         = misal_q;
`else
    assign rsp_misaligned         = 1'b0;
`endif

endmodule

// File: doc/riscv_pmp_gate.md
# riscv_pmp_gate

Single-outstanding memory access gate placed directly downstream of the address/translation stage and wrapped around the PMP checker. It does three things:
- captures one physical access,
- presents it to the PMP checker and waits for the checker's registered verdict,
- then either issues the access to the BIU or returns a PMP access-fault response without touching the bus.

Bus errors and read data are returned on the same response port.

## Interface
Parameters:
- XLEN, 32, data width
- PLEN, XLEN==32 ? 34 : 56, physical address width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- up_req  in  1  access request from upstream
- up_ack  out  1  request accepted (high only in IDLE)
- up_adr  in  PLEN  physical address
- up_size  in  biu_size_t  transfer size
- up_we  in  1  write enable
- up_instruction  in  1  instruction fetch
- up_d  in  XLEN  write data
- pmp_access_req  out  1  checker request
- pmp_access_adr  out  PLEN  held address to checker
- pmp_access_size  out  biu_size_t  held size to checker
- pmp_access_we  out  1  held we to checker
- pmp_access_instruction  out  1  held instruction flag to checker
- pmp_access_exception  in  1  checker verdict, registered one cycle after pmp_access_req
- biu_stb  out  1  bus strobe
- biu_stb_ack  in  1  strobe accepted
- biu_adri  out  PLEN  bus address
- biu_size  out  biu_size_t  bus size
- biu_we  out  1  bus write
- biu_d  out  XLEN  bus write data
- biu_q  in  XLEN  bus read data
- biu_ack  in  1  transfer complete
- biu_err  in  1  transfer error
- rsp_valid  out  1  one-cycle response strobe
- rsp_q  out  XLEN  read data (zero on faults and writes)
- rsp_pmp_fault  out  1  PMP access fault
- rsp_bus_err  out  1  bus error
- rsp_misaligned  out  1  misaligned access

## Operation
States: IDLE, CHECK, RESOLVE, ISSUE, WAIT, RSP.
- **IDLE:** up_ack=1. When up_req=1, capture adr/size/we/instruction/d into holding registers and go to CHECK.
- **CHECK:** pmp_access_req=1; pmp_access_* are driven from the holding registers. Go to RESOLVE.
- **RESOLVE:** sample pmp_access_exception.
  - 1: set rsp_pmp_fault, go to RSP.
  - 0: go to ISSUE.
- **ISSUE:** biu_stb=1 with held fields, held until biu_stb_ack.
  - On biu_stb_ack: go to WAIT, unless biu_ack or biu_err arrives in the same cycle, in which case complete directly (go to RSP).
- **WAIT:** wait for biu_ack or biu_err, then go to RSP.
  - biu_err: set rsp_bus_err.
  - biu_ack with we=0: latch biu_q into rsp_q.
- **RSP:** rsp_valid=1 for exactly one cycle; go to IDLE. Flags clear on the next accept.

Rules:
- pmp_access_req is high only in CHECK. The pmp_access_* outputs are stable from CHECK through RESOLVE.
- biu_ack and biu_err high in the same cycle: the error wins, rsp_q=0.
- At most one of rsp_pmp_fault, rsp_bus_err, rsp_misaligned is set.
- up_req outside IDLE is ignored: no capture, up_ack=0. Upstream holds the request until up_ack.
- biu_ack/biu_err in IDLE, CHECK, RESOLVE or RSP are ignored.

## Timing
- Reset: state=IDLE; holding registers=0; all outputs 0 except up_ack=1.
- Reset mid-transaction forces IDLE on the next edge and drops biu_stb. The BIU is reset by the same rst, so no stale biu_ack is consumed.
- Accept at edge 0 (IDLE & up_req). Then: CHECK in cycle 1, RESOLVE in cycle 2.
- PMP fault: rsp_valid in cycle 3; the next request can be accepted in cycle 4.
- Zero-wait bus (stb_ack and ack in cycle 3): rsp_valid in cycle 4, so minimum bus-path latency is 4 cycles.
- Each stb_ack wait cycle and each ack wait cycle adds one cycle.

## Configuration
Macro: RV_PMPGATE_MISALIGN_CHK_EN.
- **Defined:** in CHECK, the held address is tested for misalignment.
  - Misaligned means: HWORD with adr[0]≠0, WORD with adr[1:0]≠0, or DWORD with adr[2:0]≠0.
  - If misaligned: pmp_access_req is still asserted, but the verdict is discarded. RESOLVE goes to RSP with rsp_misaligned=1 and no bus access. Misalignment takes priority over a PMP fault.
- **Undefined:** no alignment check; rsp_misaligned is tied to 0.

## Test plan
- PMP allow, read, zero-wait bus: up_adr=0x1000, WORD, we=0; pmp_access_exception=0; stb_ack and ack in cycle 3 with biu_q=0xDEADBEEF -> rsp_valid in cycle 4, rsp_q=0xDEADBEEF, all flags 0.
- PMP deny: pmp_access_exception=1 in RESOLVE -> biu_stb never asserted; rsp_valid in cycle 3 with rsp_pmp_fault=1, rsp_q=0.
- Bus error with stalls: stb_ack delayed 2 cycles, then biu_ack=biu_err=1 together -> rsp_bus_err=1, rsp_q=0, rsp_valid exactly once.
- Back-to-back: up_req held high continuously -> up_ack low from CHECK through RSP; the second request is captured in the first IDLE cycle after RSP with its own address.
- Reset mid-WAIT: rst=1 for one cycle -> next cycle IDLE, biu_stb=0, rsp_valid=0, up_ack=1; a later biu_ack is ignored.
- With RV_PMPGATE_MISALIGN_CHK_EN: WORD at 0x1002 -> rsp_misaligned=1 in cycle 3, no biu_stb, even if pmp_access_exception=1.
